conv_encoder_tx: RTL and testbench
==================================

// Module: conv_encoder_tx
// PURPOSE
//   Transmit-side framer and convolutional encoder for the serial Viterbi link.
//   - Collects DATA_BITS info bits and appends K-1 zero tail bits, so every frame is terminated.
//   - Encodes with rate 1/2, constraint length K, and emits FRAME_LEN = 2*(DATA_BITS+K-1) coded bits serially.
//   - Defaults give 5+2 -> 14 bits, the frame the Viterbi decoder consumes.
// PARAMETERS
//   DATA_BITS  5       info bits per frame
//   K          3       constraint length (shift register depth incl. current bit)
//   G1         3'b111  generator for coded bit c0; bit K-1 weights newest input
//   G2         3'b101  generator for coded bit c1
// PORTS
//   clk1        in   1  single clock, rising edge
//   reset       in   1  asynchronous, active-high; clears all state
//   in_bit      in   1  info bit; first accepted = first bit of frame
//   in_valid    in   1  in_bit valid
//   in_ready    out  1  block accepts an info bit this cycle
//   out_bit     out  1  coded serial bit
//   out_valid   out  1  out_bit valid
//   out_ready   in   1  sink takes out_bit this cycle (tie 1 for free-running link)
//   frame_start out  1  high with coded bit 0 of a frame
//   frame_end   out  1  high with coded bit FRAME_LEN-1 of a frame
// BEHAVIOUR
//   Reset values
//   - State LOAD; counters and shift register 0.
//   - out_bit=0, out_valid=0, frame_start=0, frame_end=0.
//   - in_ready=1, because in_ready = (state==LOAD).
//   State machine: LOAD -> EMIT -> LOAD
//   - LOAD: each in_valid&&in_ready cycle stores in_bit at info[cnt] and increments cnt.
//     After the DATA_BITS-th accept, go to EMIT next cycle with step=0, phase=0, sr=0.
//   - EMIT: step 0..DATA_BITS+K-2. u = info[step] for step<DATA_BITS, else 0 (tail).
//     sr = {u, previous K-1 inputs}.
//     c0 = ^(sr & G1), c1 = ^(sr & G2).
//     phase 0 emits c0, phase 1 emits c1, so coded bit 2*step = c0 and 2*step+1 = c1.
//   Output timing
//   - out_bit, out_valid, frame_start and frame_end are registered.
//   - The first coded bit appears the cycle after entering EMIT, giving 1 cycle latency from the last info accept.
//   Output handshake
//   - A bit transfers when out_valid&&out_ready.
//   - While out_ready=0, out_bit and the flags hold stable and no advance occurs.
//   - After the transfer of the last bit (frame_end), out_valid drops and the state returns to LOAD.
//     in_ready=1 on the following cycle; the FSM does not overlap frames.
//   - Encoder memory sr advances only on phase-1 transfers. It is cleared at every frame start; tail bits return it to 0.
//   Counters
//   - cnt, step and bit index are sized $clog2(max+1).
//   - Wrap to 0 at end of frame; no free-running wrap.
//   Boundaries
//   - in_valid during EMIT is ignored (in_ready=0); no bit is lost or captured.
//   - out_ready=0 on the frame_end bit holds it; LOAD is entered only after acceptance.
//   - reset asserted mid-LOAD or mid-EMIT discards the partial frame immediately and returns to reset values.
//   - With out_ready held 1, a frame occupies exactly FRAME_LEN consecutive out_valid cycles.
// CONFIGURATION
//   CONV_ERR_INJECT_EN defined
//   - Adds ports inj_en (in, 1) and inj_pos (in, $clog2(FRAME_LEN)).
//   - Both are sampled on the cycle the FSM enters EMIT.
//   - If inj_en=1 and inj_pos<FRAME_LEN, coded bit inj_pos of that frame is inverted; exactly one bit per frame.
//   - Encoder memory is unaffected by the injection.
//   CONV_ERR_INJECT_EN undefined
//   - Ports are absent and the output is the clean encoding.
// TESTING
//   1. Reset held 3 cycles -> out_valid=0, frame_start=0, in_ready=1. Release with no input -> outputs stay idle.
//   2. Info 1,0,1,1,0 with out_ready=1 -> 14 bits 1,1,1,0,0,0,0,1,0,1,1,1,0,0 (word bit0-first 0x0E87).
//      frame_start on bit0, frame_end on bit13.
//   3. Info 0,0,0,0,0 -> 14 zero bits. Then info 1,0,1,1,0 -> 0x0E87, proving sr is cleared between frames.
//   4. Frame 2 with out_ready=0 for 4 cycles at bit 5 -> bit 5 (=0) held stable, sequence unchanged.
//      in_valid pulses during EMIT are ignored.
//   5. Assert reset at bit 7 of frame 2, release, send 0,0,0,0,0 -> only zeros emitted; no residue.
//   6. [CONV_ERR_INJECT_EN] frame 2 with inj_en=1, inj_pos=3 -> word 0x0E8F.
//      With inj_pos=15 (>=FRAME_LEN) -> 0x0E87.

Source files
------------

// File: rtl/conv_encoder_tx.sv
// -----------------------------------------------------------------------------
// conv_encoder_tx
//   Transmit-side framer and rate-1/2 convolutional encoder for the serial
//   Viterbi link. Collects DATA_BITS info bits, appends K-1 zero tail bits and
//   emits FRAME_LEN = 2*(DATA_BITS+K-1) coded bits serially (c0 then c1 per
//   input step). Frames never overlap: LOAD -> EMIT -> LOAD.
//
// Optional feature macro: CONV_ERR_INJECT_EN
//   When defined, adds inj_en / inj_pos. Both are sampled when the FSM enters
//   EMIT; if inj_en=1, coded bit inj_pos of that frame is inverted on the wire
//   (positions >= FRAME_LEN never match). Encoder memory is unaffected.
//
// Ports
//   clk1        in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   in_bit      in   info bit (first accepted = first bit of frame)
//   in_valid    in   in_bit valid
//   in_ready    out  high while collecting info bits (state LOAD)
//   out_bit     out  registered coded serial bit
//   out_valid   out  out_bit valid
//   out_ready   in   sink takes out_bit this cycle
//   frame_start out  high with coded bit 0
//   frame_end   out  high with coded bit FRAME_LEN-1
//   inj_en      in   (CONV_ERR_INJECT_EN only) invert one coded bit this frame
//   inj_pos     in   (CONV_ERR_INJECT_EN only) index of the bit to invert
// -----------------------------------------------------------------------------
module conv_encoder_tx #(
    parameter int             DATA_BITS = 5,
    parameter int             K         = 3,
    parameter logic [K-1:0]   G1        = 3'b111,
    parameter logic [K-1:0]   G2        = 3'b101
) (
    input  logic clk1,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic frame_start,
    output logic frame_end
`ifdef CONV_ERR_INJECT_EN
    ,
    input  logic inj_en,
    input  logic [$clog2(2*(DATA_BITS+K-1))-1:0] inj_pos
`endif
);

    localparam int NSTEPS    = DATA_BITS + K - 1;
    localparam int FRAME_LEN = 2 * NSTEPS;
    localparam int CNT_W     = $clog2(DATA_BITS + 1);
    localparam int STEP_W    = $clog2(NSTEPS + 1);
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [STEP_W-1:0] STEP_DATA = STEP_W'(DATA_BITS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NSTEPS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STEP_W-1:0]  r_step;
    logic               r_phase;
    logic [K-2:0]       r_sr;       // previous K-1 inputs, bit K-2 is the newest
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_out_bit;
    logic               r_out_valid;
    logic               r_frame_start;
    logic               r_frame_end;

    logic [DATA_BITS-1:0] w_info;
    logic                 w_accept;
    logic                 w_u;
    logic [K-1:0]         w_sr_full;
    logic                 w_coded;
    logic                 w_flip;
    logic                 w_advance;

    assign w_accept = in_valid && (r_state == S_LOAD);

    // One storage flop per info position; position gi is written by the
    // gi-th accepted bit of the frame.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_info
            logic r_info_bit;
            always_ff @(posedge clk1 or posedge reset) begin
                if (reset) begin
                    r_info_bit <= 1'b0;
                end else if (w_accept && (r_cnt == CNT_W'(gi))) begin
                    r_info_bit <= in_bit;
                end
            end
            assign w_info[gi] = r_info_bit;
        end
    endgenerate

    // Encoder datapath: current input (zero during the tail) joined with memory.
    always_comb begin
        w_u       = 1'b0;
        if (r_step < STEP_DATA) begin
            w_u = w_info[r_step];
        end
        w_sr_full = {w_u, r_sr};
        w_coded   = r_phase ? ^(w_sr_full & G2) : ^(w_sr_full & G1);
    end

`ifdef CONV_ERR_INJECT_EN
    logic                                      r_inj_en;
    logic [$clog2(2*(DATA_BITS+K-1))-1:0]      r_inj_pos;

    // Captured on the same edge that moves the FSM into EMIT.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_inj_en  <= 1'b0;
            r_inj_pos <= '0;
        end else if (w_accept && (r_cnt == CNT_LAST)) begin
            r_inj_en  <= inj_en;
            r_inj_pos <= inj_pos;
        end
    end

    assign w_flip = r_inj_en && (r_bit_idx == IDX_W'(r_inj_pos));
`else
    assign w_flip = 1'b0;
`endif

    // The output register may be (re)loaded when it is empty or being taken.
    assign w_advance = !r_out_valid || out_ready;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_step        <= '0;
            r_phase       <= 1'b0;
            r_sr          <= '0;
            r_bit_idx     <= '0;
            r_out_bit     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_out_valid   <= 1'b0;
                    r_frame_start <= 1'b0;
                    r_frame_end   <= 1'b0;
                    if (w_accept) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt     <= '0;
                            r_state   <= S_EMIT;
                            r_step    <= '0;
                            r_phase   <= 1'b0;
                            r_sr      <= '0;
                            r_bit_idx <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (w_advance) begin
                        if (r_out_valid && r_frame_end) begin
                            // Last coded bit just transferred: frame done.
                            r_state       <= S_LOAD;
                            r_out_valid   <= 1'b0;
                            r_out_bit     <= 1'b0;
                            r_frame_start <= 1'b0;
                            r_frame_end   <= 1'b0;
                            r_step        <= '0;
                            r_phase       <= 1'b0;
                            r_bit_idx     <= '0;
                        end else begin
                            r_out_bit     <= w_coded ^ w_flip;
                            r_out_valid   <= 1'b1;
                            r_frame_start <= (r_bit_idx == '0);
                            r_frame_end   <= (r_bit_idx == IDX_LAST);
                            r_bit_idx     <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IDX_W'(1);
                            if (r_phase) begin
                                // Both coded bits of this step are out: shift memory.
                                r_phase <= 1'b0;
                                r_sr    <= w_sr_full[K-1:1];
                                r_step  <= (r_step == STEP_LAST) ? '0 : r_step + STEP_W'(1);
                            end else begin
                                r_phase <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready    = (r_state == S_LOAD);
    assign out_bit     = r_out_bit;
    assign out_valid   = r_out_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

endmodule

// File: tb/tb_conv_encoder_tx.sv
module tb_conv_encoder_tx;

    localparam int DB = 5;
    localparam int KK = 3;
    localparam int NS = DB + KK - 1;
    localparam int FL = 2 * NS;

    logic clk1 = 1'b0;
    logic reset;
    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic out_ready;
    logic frame_start;
    logic frame_end;
`ifdef CONV_ERR_INJECT_EN
    logic       inj_en;
    logic [3:0] inj_pos;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk1 = ~clk1;

    conv_encoder_tx dut (
        .clk1        (clk1),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end)
`ifdef CONV_ERR_INJECT_EN
        ,
        .inj_en      (inj_en),
        .inj_pos     (inj_pos)
`endif
    );

    // Reference: coded bit 2t / 2t+1 is the mod-2 convolution of the padded
    // info sequence with G1 / G2 (generator bit K-1 weights the current input).
    function automatic logic [FL-1:0] ref_frame(input logic [DB-1:0] info);
        logic [FL-1:0] f;
        logic [KK-1:0] g1;
        logic [KK-1:0] g2;
        int x[NS];
        int c0;
        int c1;
        g1 = 3'b111;
        g2 = 3'b101;
        f  = '0;
        for (int t = 0; t < NS; t++) x[t] = (t < DB) ? int'(info[t]) : 0;
        for (int t = 0; t < NS; t++) begin
            c0 = 0;
            c1 = 0;
            for (int j = 0; j < KK; j++) begin
                if (t - j >= 0) begin
                    c0 = c0 ^ (int'(g1[KK-1-j]) & x[t-j]);
                    c1 = c1 ^ (int'(g2[KK-1-j]) & x[t-j]);
                end
            end
            f[2*t]   = c0[0];
            f[2*t+1] = c1[0];
        end
        return f;
    endfunction

    // Called at a falling edge; returns at the falling edge after the last accept.
    task automatic send_info(input logic [DB-1:0] info, output bit tmo);
        int guard;
        tmo = 1'b0;
        for (int i = 0; i < DB; i++) begin
            in_bit   = info[i];
            in_valid = 1'b1;
            guard    = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk1);
                guard++;
            end
            if (guard >= 50) tmo = 1'b1;
            @(negedge clk1);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    // Collects one frame; returns at the falling edge after the last transfer.
    task automatic collect_frame(input int stall_at, input int stall_len,
                                 input bit rand_rdy, input bit pulse_in,
                                 output logic [FL-1:0] word,
                                 output logic [FL-1:0] smask,
                                 output logic [FL-1:0] emask,
                                 output int first_wait, output int hold_bad,
                                 output int vcycles, output bit tmo);
        int   idx;
        int   guard;
        bit   seen;
        bit   stalled;
        logic rdy;
        logic hb, hs, he;
        idx = 0; guard = 0; seen = 0; stalled = 0;
        word = '0; smask = '0; emask = '0;
        first_wait = 0; hold_bad = 0; vcycles = 0;
        while (idx < FL && guard < 400) begin
            guard++;
            if (pulse_in) begin
                in_valid = 1'($urandom_range(0, 1));
                in_bit   = 1'($urandom_range(0, 1));
            end
            if (out_valid === 1'b1 && idx == stall_at && !stalled) begin
                stalled   = 1;
                hb        = out_bit;
                hs        = frame_start;
                he        = frame_end;
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk1);
                    if (out_valid !== 1'b1 || out_bit !== hb || frame_start !== hs || frame_end !== he)
                        hold_bad++;
                end
            end
            rdy       = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = rdy;
            if (out_valid === 1'b1) begin
                seen = 1;
                vcycles++;
                if (rdy) begin
                    word[idx]  = out_bit;
                    smask[idx] = frame_start;
                    emask[idx] = frame_end;
                    idx++;
                end
            end else if (!seen) begin
                first_wait++;
            end
            @(negedge clk1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        tmo       = (idx < FL);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk1);
            n_vec++;
            if ({out_valid, frame_start, frame_end, out_bit, in_ready} !== 5'b00001) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got {ov,fs,fe,ob,ir}=%b want 00001", c,
                         {out_valid, frame_start, frame_end, out_bit, in_ready});
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk1);
            n_vec++;
            if ({out_valid, frame_start, frame_end, in_ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got {ov,fs,fe,ir}=%b want 0001", c,
                         {out_valid, frame_start, frame_end, in_ready});
            end
        end
        $display("test_reset done");
    endtask

    task automatic run_frame(input string name, input logic [DB-1:0] info,
                             input logic [FL-1:0] want, input int stall_at,
                             input int stall_len, input bit rand_rdy, input bit pulse_in);
        logic [FL-1:0] word, sm, em;
        int fw, hb, vc;
        bit t1, t2;
        send_info(info, t1);
        collect_frame(stall_at, stall_len, rand_rdy, pulse_in, word, sm, em, fw, hb, vc, t2);
        n_vec++;
        if (t1 || t2) begin
            n_bad++;
            $display("FAIL %s timeout send=%0d collect=%0d want 0 0", name, t1, t2);
        end
        n_vec++;
        if (word !== want) begin
            n_bad++;
            $display("FAIL %s word got %h want %h", name, word, want);
        end
        n_vec++;
        if (sm !== 14'h0001 || em !== 14'h2000) begin
            n_bad++;
            $display("FAIL %s flags start=%h end=%h want 0001 2000", name, sm, em);
        end
        n_vec++;
        if (hb !== 0) begin
            n_bad++;
            $display("FAIL %s hold changed %0d times want 0", name, hb);
        end
        if (!rand_rdy && stall_len == 0) begin
            n_vec++;
            if (fw !== 1 || vc !== FL) begin
                n_bad++;
                $display("FAIL %s timing latency=%0d valid_cycles=%0d want 1 %0d", name, fw, vc, FL);
            end
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_end in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
        end
        $display("frame %s info=%b word=%h want=%h", name, info, word, want);
    endtask

    task automatic test_basic();
        n_vec++;
        if (ref_frame(5'b01101) !== 14'h0E87) begin
            n_bad++;
            $display("FAIL model_ref got %h want 0e87", ref_frame(5'b01101));
        end
        run_frame("basic", 5'b01101, 14'h0E87, -1, 0, 0, 0);
    endtask

    task automatic test_sr_clear();
        run_frame("zeros", 5'b00000, 14'h0000, -1, 0, 0, 0);
        run_frame("after_zeros", 5'b01101, 14'h0E87, -1, 0, 0, 0);
    endtask

    task automatic test_stall();
        logic [DB-1:0] info;
        run_frame("stall5", 5'b01101, 14'h0E87, 5, 4, 0, 1);
        info = 5'($urandom);
        run_frame("post_stall", info, ref_frame(info), -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int  idx;
        int  guard;
        bit  t1;
        // Mid-EMIT: abort at coded bit 7.
        send_info(5'b01101, t1);
        idx = 0; guard = 0;
        out_ready = 1'b1;
        while (!(out_valid === 1'b1 && idx == 7) && guard < 100) begin
            if (out_valid === 1'b1) idx++;
            @(negedge clk1);
            guard++;
        end
        n_vec++;
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL reset_mid_reach idx=%0d want 7", idx);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_end !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async out_valid=%b in_ready=%b frame_end=%b want 0 1 0",
                     out_valid, in_ready, frame_end);
        end
        @(negedge clk1);
        @(negedge clk1);
        reset = 1'b0;
        run_frame("after_emit_reset", 5'b00000, 14'h0000, -1, 0, 0, 0);
        // Mid-LOAD: two bits accepted, then reset discards them.
        in_bit = 1'b1; in_valid = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk1);
        reset = 1'b0;
        run_frame("after_load_reset", 5'b01101, 14'h0E87, -1, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [DB-1:0] info;
        for (int f = 0; f < 20; f++) begin
            info = 5'($urandom);
            run_frame($sformatf("rand%0d", f), info, ref_frame(info), -1, 0, 1, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef CONV_ERR_INJECT_EN
    task automatic test_inject();
        inj_en = 1'b1; inj_pos = 4'd3;
        run_frame("inj3", 5'b01101, 14'h0E8F, -1, 0, 0, 0);
        inj_en = 1'b1; inj_pos = 4'd15;
        run_frame("inj15", 5'b01101, 14'h0E87, -1, 0, 0, 0);
        inj_en = 1'b1; inj_pos = 4'd13;
        run_frame("inj13", 5'b10011, ref_frame(5'b10011) ^ 14'h2000, -1, 0, 0, 0);
        inj_en = 1'b0; inj_pos = 4'd0;
        run_frame("inj_off", 5'b01101, 14'h0E87, -1, 0, 0, 0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef CONV_ERR_INJECT_EN
        inj_en    = 1'b0;
        inj_pos   = 4'd0;
`endif
        test_reset();
        test_basic();
        test_sr_clear();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef CONV_ERR_INJECT_EN
        test_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
